// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: FSM states,
// register offsets, CTRL bit positions and the counting modes.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_t;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_AUTO    = 2'd1,
    MODE_RSV2    = 2'd2,
    MODE_RSV3    = 2'd3
  } tc_mode_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_BITS     = 4;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Register reads are combinational; irq = CTRL.IM & irq_flag.
module timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  import tc_pkg::*;

  // Bus handshake: there is no ready/stall. A store is accepted on every rising
  // edge where sel & we are both high; it lands in the register at that edge and
  // the FSM observes the new value from the following cycle onward.

  logic [CTRL_BITS-1:0] ctrl;
  logic [WIDTH-1:0]     preset;
  logic [WIDTH-1:0]     count;
  logic                 irq_flag;
  tc_state_t            state;

  logic     ctrl_wr;
  logic     preset_wr;
  logic     ctrl_en;
  tc_mode_t ctrl_mode;
  logic     auto_reload;

  assign ctrl_wr     = sel & we & (addr == ADDR_CTRL);
  assign preset_wr   = sel & we & (addr == ADDR_PRESET);
  assign ctrl_en     = ctrl[CTRL_EN];
  assign ctrl_mode   = tc_mode_t'(ctrl[CTRL_MODE_LSB +: 2]);
  assign auto_reload = (ctrl_mode == MODE_AUTO);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else begin
      if (preset_wr) preset <= wdata[WIDTH-1:0];

      case (state)
        IDLE: if (ctrl_en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count != '0) begin
            count <= count - WIDTH'(1);
          end else begin
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (auto_reload) begin
            irq_flag <= 1'b0;
            state    <= ctrl_en ? LOAD : IDLE;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed last so a CPU store outranks the FSM's own EN clear in INT.
      if (ctrl_wr) begin
        ctrl <= wdata[CTRL_BITS-1:0];
        if (wdata[CTRL_EN]) irq_flag <= 1'b0;
      end
    end
  end

  assign irq = ctrl[CTRL_IM] & irq_flag;

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = 32'(ctrl);
      ADDR_PRESET: rdata = 32'(preset);
      ADDR_COUNT:  rdata = 32'(count);
      default:     rdata = '0;
    endcase
  end

endmodule
